multicycle_control_fsm: RTL and testbench

Main control state machine for the multicycle RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the IR/PC registers and the register file across FETCH/DECODE/EXECUTE/MEM/WB states. It drives the 2-bit ALUOp consumed by the ALU decoder and selects the operand muxes, so that one ALU serves PC increment, branch-target, address and execute computations.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/control_output_decode.sv | 103 ++++++++++
 rtl/multicycle_control_fsm.sv | 115 +++++++++++
 tb/tb_multicycle_control_fsm.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control FSM: state encoding, opcodes, mux selects.
// Ports: none (package); imported by control_output_decode and multicycle_control_fsm.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_IALU) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/control_output_decode.sv
// Combinational map from control state (+ mem ready, ALU zero) to datapath controls.
// Ports: state, mem_ready, zero in; alu_op, src selects, adr_src, strobes, illegal_op out.
module control_output_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal_op
);

    logic pc_update;
    logic branch;

    always_comb begin
        alu_op     = ALU_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                // precompute branch target into ALUOut
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_JAL: begin
                // link value OldPC+4 computed while PC takes the target
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_update = 1'b1;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core (state register + next-state logic).
// Ports: clk, reset, op, zero, mem_ready in; ALU/mux selects and strobes out.
// Build option CTRL_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP instead of a NOP.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state;
    state_t state_next;
    logic   rdy;
    logic   op_known;
    logic   nop_done;

    logic ir_write_d;
    logic pc_write_d;
    logic reg_write_d;
    logic mem_write_d;
    logic instr_done_d;
    logic illegal_op_d;

    assign rdy      = USE_MEM_READY ? mem_ready : 1'b1;
    assign op_known = is_known_op(op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW,
                    OP_SW:   state_next = S_MEMADR;
                    OP_R:    state_next = S_EXECUTER;
                    OP_IALU: state_next = S_EXECUTEI;
                    OP_BEQ:  state_next = S_BEQ;
                    OP_JAL:  state_next = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default: state_next = S_TRAP;
`else
                    default: state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_next = S_TRAP;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign nop_done = 1'b0;
`else
    // unknown opcode retires as a NOP straight out of DECODE
    assign nop_done = (state == S_DECODE) && !op_known;
`endif

    control_output_decode u_dec (
        .state      (state),
        .mem_ready  (rdy),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write_d),
        .pc_write   (pc_write_d),
        .reg_write  (reg_write_d),
        .mem_write  (mem_write_d),
        .instr_done (instr_done_d),
        .illegal_op (illegal_op_d)
    );

    // FETCH is a live state during reset, so strobes are masked directly
    assign ir_write   = ir_write_d   & ~reset;
    assign pc_write   = pc_write_d   & ~reset;
    assign reg_write  = reg_write_d  & ~reset;
    assign mem_write  = mem_write_d  & ~reset;
    assign instr_done = (instr_done_d | nop_done) & ~reset;
    assign illegal_op = illegal_op_d & ~reset;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm.
// Output vector: {alu_op,src_a,src_b,result_src,adr_src,ir,pc,reg,mem,done,illegal}.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    logic [14:0] obs;
    assign obs = {alu_op, alu_src_a, alu_src_b, result_src, adr_src,
                  ir_write, pc_write, reg_write, mem_write, instr_done, illegal_op};

    localparam logic [14:0] F_R    = 15'b00_00_10_10_0_110000;
    localparam logic [14:0] F_NR   = 15'b00_00_10_10_0_000000;
    localparam logic [14:0] DEC    = 15'b00_01_01_00_0_000000;
    localparam logic [14:0] DEC_IL = 15'b00_01_01_00_0_000010;
    localparam logic [14:0] MADR   = 15'b00_10_01_00_0_000000;
    localparam logic [14:0] MRD    = 15'b00_00_00_00_1_000000;
    localparam logic [14:0] MWB    = 15'b00_00_00_01_0_001010;
    localparam logic [14:0] MWR_NR = 15'b00_00_00_00_1_000100;
    localparam logic [14:0] MWR_R  = 15'b00_00_00_00_1_000110;
    localparam logic [14:0] EXR    = 15'b10_10_00_00_0_000000;
    localparam logic [14:0] EXI    = 15'b10_10_01_00_0_000000;
    localparam logic [14:0] ALUWB  = 15'b00_00_00_00_0_001010;
    localparam logic [14:0] JALS   = 15'b00_01_10_00_0_010000;
    localparam logic [14:0] BEQ_Z  = 15'b01_10_00_00_0_010010;
    localparam logic [14:0] BEQ_NZ = 15'b01_10_00_00_0_000010;
    localparam logic [14:0] TRAPS  = 15'b00_00_00_00_0_000001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op = 7'h00;
        zero = 1'b0;
        mem_ready = 1'b1;
        #2;
        tick();
        @(negedge clk);
        checks++;
        if (obs !== F_NR) begin
            errors++;
            $display("FAIL reset_hold got %b exp %b", obs, F_NR);
        end
        tick();
        reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== F_NR) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", obs, F_NR);
        end
        tick();
    endtask

    task automatic test_reset_mid_memwrite();
        logic [14:0] ev [4];
        logic        rd [4];
        ev = '{F_R, DEC, MADR, MWR_NR};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0};
        op = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL rst_sw cyc%0d got %b exp %b", i, obs, ev[i]);
            end
            if (i < 3) tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || obs !== F_NR) begin
            errors++;
            $display("FAIL rst_async got %b exp %b", obs, F_NR);
        end
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== F_R) begin
            errors++;
            $display("FAIL rst_first_fetch got %b exp %b", obs, F_R);
        end
        tick();
        ev = '{DEC, MADR, MWR_R, F_NR};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL rst_sw_resume cyc%0d got %b exp %b", i, obs, ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_add();
        logic [14:0] ev [5];
        ev = '{F_R, DEC, EXR, ALUWB, F_NR};
        op = 7'b0110011;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL add cyc%0d got %b exp %b", i, obs, ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] ev [8];
        logic        rd [8];
        ev = '{F_R, DEC, MADR, MRD, MRD, MRD, MWB, F_NR};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        op = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL lw_wait cyc%0d got %b exp %b", i, obs, ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_sw_fetch_wait();
        logic [14:0] ev [8];
        logic        rd [8];
        ev = '{F_NR, F_NR, F_R, DEC, MADR, MWR_NR, MWR_R, F_NR};
        rd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        op = 7'b0100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL sw_wait cyc%0d got %b exp %b", i, obs, ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_beq();
        logic [14:0] ev [4];
        op = 7'b1100011;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            ev = '{F_R, DEC, (z == 1) ? BEQ_Z : BEQ_NZ, F_NR};
            for (int i = 0; i < 4; i++) begin
                mem_ready = (i == 3) ? 1'b0 : 1'b1;
                @(negedge clk);
                checks++;
                if (obs !== ev[i]) begin
                    errors++;
                    $display("FAIL beq_z%0d cyc%0d got %b exp %b", z, i, obs, ev[i]);
                end
                tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [14:0] ev [5];
        ev = '{F_R, DEC, JALS, ALUWB, F_NR};
        op = 7'b1101111;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL jal cyc%0d got %b exp %b", i, obs, ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] ev [9];
        ev = '{F_R, DEC, EXR, ALUWB, F_R, DEC, EXI, ALUWB, F_NR};
        for (int i = 0; i < 9; i++) begin
            op = (i < 4) ? 7'b0110011 : 7'b0010011;
            mem_ready = (i == 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL b2b cyc%0d got %b exp %b", i, obs, ev[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        op = 7'b1111111;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== F_R) begin
            errors++;
            $display("FAIL ill_fetch got %b exp %b", obs, F_R);
        end
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        @(negedge clk);
        checks++;
        if (obs !== DEC) begin
            errors++;
            $display("FAIL ill_decode got %b exp %b", obs, DEC);
        end
        tick();
        for (int i = 0; i < 12; i++) begin
            mem_ready = i[0];
            zero = i[1];
            @(negedge clk);
            checks++;
            if (obs !== TRAPS) begin
                errors++;
                $display("FAIL ill_trap cyc%0d got %b exp %b", i, obs, TRAPS);
            end
            tick();
        end
        reset = 1'b1;
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== F_NR) begin
            errors++;
            $display("FAIL ill_recover got %b exp %b", obs, F_NR);
        end
        tick();
`else
        @(negedge clk);
        checks++;
        if (obs !== DEC_IL) begin
            errors++;
            $display("FAIL ill_nop_decode got %b exp %b", obs, DEC_IL);
        end
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== F_NR) begin
            errors++;
            $display("FAIL ill_nop_fetch got %b exp %b", obs, F_NR);
        end
        tick();
        checks++;
        if (TRAPS[0] !== 1'b1 || illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL ill_flag got %b exp 0", illegal_op);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_memwrite();
        test_add();
        test_lw_wait();
        test_sw_fetch_wait();
        test_beq();
        test_jal();
        test_back_to_back();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
